// File: rtl/nanosoc_cpu_ahb_pkg.sv
// Shared types for the CPU 0 AHB-Lite decoder: data-phase select codes,
// default-slave states, HTRANS encodings and the window-match helper.
package nanosoc_cpu_ahb_pkg;

  typedef enum logic [2:0] {
    DSEL_NONE = 3'd0,
    DSEL_BOOT = 3'd1,
    DSEL_IMEM = 3'd2,
    DSEL_DMEM = 3'd3,
    DSEL_DEF  = 3'd4,
    DSEL_EXP  = 3'd5
  } dsel_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // A window of 2^addr_w bytes matches when all address bits above the
  // window offset equal those of the base.
  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          addr_w);
    return (addr >> addr_w) == (base >> addr_w);
  endfunction

endpackage

// File: rtl/nanosoc_ahb_default_slave.sv
// Default slave for unmapped addresses: answers every accepted NONSEQ/SEQ
// with the two-cycle AHB ERROR response. IDLE/BUSY never reach it.
module nanosoc_ahb_default_slave
  import nanosoc_cpu_ahb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hready,
  input  logic      trans_req,
  input  logic      unmapped,
  output logic      hreadyout,
  output logic      hresp,
  output ds_state_t state
);

  logic accept;

  assign accept = hready & trans_req & unmapped;

  // Error-response FSM; hreadyout/hresp are registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DS_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
    end else begin
      case (state)
        DS_IDLE: begin
          if (accept) begin
            state     <= DS_ERR1;
            hreadyout <= 1'b0;
            hresp     <= 1'b1;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          // Second error cycle; a new unmapped transfer accepted here
          // restarts the response directly.
          if (accept) begin
            state     <= DS_ERR1;
            hreadyout <= 1'b0;
            hresp     <= 1'b1;
          end else begin
            state     <= DS_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/nanosoc_cpu_ahb_decoder.sv
// CPU 0 AHB-Lite decoder: address-phase HSEL decode, registered data-phase
// select, response mux and sticky capture of the first unmapped access.
// Optional expansion window enabled by NANOSOC_CPU_DECODE_EXP_EN; without
// it that window falls to the default slave.
module nanosoc_cpu_ahb_decoder
  import nanosoc_cpu_ahb_pkg::*;
#(
  parameter logic [31:0] BOOTROM_BASE    = 32'h1000_0000,
  parameter int          BOOTROM_ADDR_W  = 10,
  parameter logic [31:0] IMEM_BASE       = 32'h0000_0000,
  parameter int          IMEM_RAM_ADDR_W = 14,
  parameter logic [31:0] DMEM_BASE       = 32'h2000_0000,
  parameter int          DMEM_RAM_ADDR_W = 14
`ifdef NANOSOC_CPU_DECODE_EXP_EN
  ,
  parameter logic [31:0] EXP_BASE        = 32'h4000_0000,
  parameter int          EXP_ADDR_W      = 30
`endif
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  output logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        BOOTROM_HSEL,
  output logic        IMEM_HSEL,
  output logic        DMEM_HSEL,
  input  logic        BOOTROM_HREADYOUT,
  input  logic        IMEM_HREADYOUT,
  input  logic        DMEM_HREADYOUT,
  input  logic [31:0] BOOTROM_HRDATA,
  input  logic [31:0] IMEM_HRDATA,
  input  logic [31:0] DMEM_HRDATA,
  input  logic        BOOTROM_HRESP,
  input  logic        IMEM_HRESP,
  input  logic        DMEM_HRESP,
`ifdef NANOSOC_CPU_DECODE_EXP_EN
  output logic        EXP_HSEL,
  input  logic        EXP_HREADYOUT,
  input  logic [31:0] EXP_HRDATA,
  input  logic        EXP_HRESP,
`endif
  input  logic        ERR_CLR,
  output logic        ERR_VALID,
  output logic [31:0] ERR_ADDR
);

  logic      boot_hit, imem_hit, dmem_hit, unmapped, trans_req;
  logic      def_hreadyout, def_hresp, err_start;
  dsel_t     addr_region, dsel;
  ds_state_t def_state;

  assign boot_hit  = region_hit(HADDR, BOOTROM_BASE, BOOTROM_ADDR_W);
  assign imem_hit  = region_hit(HADDR, IMEM_BASE, IMEM_RAM_ADDR_W);
  assign dmem_hit  = region_hit(HADDR, DMEM_BASE, DMEM_RAM_ADDR_W);
  assign trans_req = (HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ);

  assign BOOTROM_HSEL = boot_hit;
  assign IMEM_HSEL    = imem_hit;
  assign DMEM_HSEL    = dmem_hit;

`ifdef NANOSOC_CPU_DECODE_EXP_EN
  logic exp_hit;
  assign exp_hit  = region_hit(HADDR, EXP_BASE, EXP_ADDR_W);
  assign EXP_HSEL = exp_hit;
  assign unmapped = ~(boot_hit | imem_hit | dmem_hit | exp_hit);
`else
  assign unmapped = ~(boot_hit | imem_hit | dmem_hit);
`endif

  // Address-phase decode into the select the data phase will use.
  always_comb begin
    addr_region = DSEL_NONE;
    if (boot_hit)       addr_region = DSEL_BOOT;
    else if (imem_hit)  addr_region = DSEL_IMEM;
    else if (dmem_hit)  addr_region = DSEL_DMEM;
`ifdef NANOSOC_CPU_DECODE_EXP_EN
    else if (exp_hit)   addr_region = DSEL_EXP;
`endif
    else if (trans_req) addr_region = DSEL_DEF;
  end

  // Data-phase select advances only when the current data phase completes.
  always_ff @(posedge HCLK) begin
    if (HRESET)      dsel <= DSEL_NONE;
    else if (HREADY) dsel <= addr_region;
  end

  // Route the selected slave's response back to the CPU.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    case (dsel)
      DSEL_BOOT: begin
        HREADY = BOOTROM_HREADYOUT;
        HRESP  = BOOTROM_HRESP;
        HRDATA = BOOTROM_HRDATA;
      end
      DSEL_IMEM: begin
        HREADY = IMEM_HREADYOUT;
        HRESP  = IMEM_HRESP;
        HRDATA = IMEM_HRDATA;
      end
      DSEL_DMEM: begin
        HREADY = DMEM_HREADYOUT;
        HRESP  = DMEM_HRESP;
        HRDATA = DMEM_HRDATA;
      end
      DSEL_DEF: begin
        HREADY = def_hreadyout;
        HRESP  = def_hresp;
      end
`ifdef NANOSOC_CPU_DECODE_EXP_EN
      DSEL_EXP: begin
        HREADY = EXP_HREADYOUT;
        HRESP  = EXP_HRESP;
        HRDATA = EXP_HRDATA;
      end
`endif
      default: ;
    endcase
  end

  nanosoc_ahb_default_slave u_default_slave (
    .clk       (HCLK),
    .rst       (HRESET),
    .hready    (HREADY),
    .trans_req (trans_req),
    .unmapped  (unmapped),
    .hreadyout (def_hreadyout),
    .hresp     (def_hresp),
    .state     (def_state)
  );

  // Only a fresh error sequence (leaving IDLE) is a capture candidate.
  assign err_start = (def_state == DS_IDLE) & HREADY & trans_req & unmapped;

  // Sticky first-fault capture; a coincident new fault beats the clear.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= 32'h0;
    end else if (err_start & (~ERR_VALID | ERR_CLR)) begin
      ERR_VALID <= 1'b1;
      ERR_ADDR  <= HADDR;
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
    end
  end

endmodule
